// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline stall/flush controller.
//   CTRL_WIDTH          : default number of pipeline stages
//   STG_PC .. STG_WB    : stage index constants (stage 0 is the PC stage)
//   state_t             : controller state, encoded {hold active, flush pending}
//   RST_ENABLE / STOP   : active level of reset and of a stall bit
package pipe_ctrl_pkg;

  localparam int CTRL_WIDTH = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    PEND      = 2'b01,
    HOLD      = 2'b10,
    HOLD_PEND = 2'b11
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hold_cnt.sv
// hold_cnt -- multi-cycle hold down counter with owning-stage register.
//   clk, rst     : clock, synchronous active-high reset
//   load         : hold pulse (ignored when load_cyc == 0)
//   load_cyc     : hold length in cycles, the load cycle counting as the first
//   load_stage   : stage that owns the hold
//   active       : a hold is in force this cycle (includes the load cycle)
//   active_nxt   : a hold will still be in force next cycle
//   stage        : owning stage this cycle (max-merged with a new load)
module hold_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cyc,
  input  logic [SW-1:0]    load_stage,
  output logic             active,
  output logic             active_nxt,
  output logic [SW-1:0]    stage
);

  // cnt_q = cycles of hold left, counting the current cycle; 0 means idle.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_eff;
  logic [SW-1:0]    stg_q;
  logic             take;

  assign take = load && (load_cyc != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_eff = cnt_q;
    stage   = stg_q;
    if (take) begin
      if (load_cyc > cnt_q) cnt_eff = load_cyc;
      // A new hold on an idle counter takes its stage outright; on a live
      // hold the deeper (higher-index) owner wins.
      if (cnt_q == '0 || load_stage > stg_q) stage = load_stage;
    end
  end

  assign active     = (cnt_eff != '0);
  assign active_nxt = (cnt_eff > CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    // NOTE: only control state is reset; nothing here is a memory array.
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
      stg_q <= '0;
    end else begin
      cnt_q <= active ? (cnt_eff - CNT_W'(1)) : '0;
      stg_q <= stage;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall / flush controller.
//   clk, rst              : clock, synchronous active-high reset
//   req[NSTAGE]           : level stall request per stage
//   hold_vld/stage/cyc    : one-cycle pulse starting a multi-cycle stall
//   flush_req/flush_stage : one-cycle redirect pulse and resolving stage
//   stall[NSTAGE]         : per-stage stall (stage i stalls when any stage >= i asks)
//   flush[NSTAGE]         : per-stage bubble insert, one-cycle pulse
//   busy                  : a hold or a pending flush is active
//   stall_cnt, flush_cnt  : performance counters, live only when
//                           PIPE_CTRL_PERF_EN is defined, otherwise tied to 0
// A flush is emitted only when no stage at or beyond the flush target is
// stalling; otherwise it waits as pending (deepest target kept).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = CTRL_WIDTH,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSTAGE-1:0]         req,
  input  logic                      hold_vld,
  input  logic [$clog2(NSTAGE)-1:0] hold_stage,
  input  logic [CNT_W-1:0]          hold_cyc,
  input  logic                      flush_req,
  input  logic [$clog2(NSTAGE)-1:0] flush_stage,
  output logic [NSTAGE-1:0]         stall,
  output logic [NSTAGE-1:0]         flush,
  output logic                      busy,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  localparam int SW = $clog2(NSTAGE);

  state_t          state_q, state_d;
  logic [SW-1:0]   pend_stg_q, pend_stg_d;
  logic            pend_q, pend_nxt;

  logic            hold_act, hold_act_nxt;
  logic [SW-1:0]   hold_stg;

  logic [NSTAGE-1:0] eff_req;
  logic [NSTAGE-1:0] stall_base;
  logic [NSTAGE-1:0] low_mask;
  logic [SW-1:0]     flush_tgt;
  logic              has_flush, blocked, emit_raw, emit;

  hold_cnt #(
    .CNT_W (CNT_W),
    .SW    (SW)
  ) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_vld),
    .load_cyc   (hold_cyc),
    .load_stage (hold_stage),
    .active     (hold_act),
    .active_nxt (hold_act_nxt),
    .stage      (hold_stg)
  );

  assign pend_q = (state_q == PEND) || (state_q == HOLD_PEND);

  always_comb begin
    logic acc;
    eff_req    = req;
    stall_base = '0;
    low_mask   = '0;
    acc        = 1'b0;

    for (int i = 0; i < NSTAGE; i++) begin
      if (hold_act && hold_stg == SW'(i)) eff_req[i] = 1'b1;
    end

    // Stage i stalls when it or any later stage requests: suffix OR.
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc = acc | eff_req[i];
      if (acc) stall_base[i] = STOP;
    end

    has_flush = flush_req || pend_q;
    flush_tgt = flush_stage;
    if (pend_q) begin
      flush_tgt = (flush_req && flush_stage > pend_stg_q) ? flush_stage : pend_stg_q;
    end

    for (int j = 0; j < NSTAGE; j++) begin
      low_mask[j] = (j < int'(flush_tgt));
    end

    // Any request at or beyond the target means the highest request k >= f.
    blocked  = |(eff_req & ~low_mask);
    emit_raw = has_flush && !blocked;
    emit     = emit_raw && (rst != RST_ENABLE);

    pend_nxt   = has_flush && !emit_raw;
    pend_stg_d = pend_nxt ? flush_tgt : pend_stg_q;
    state_d    = state_t'({hold_act_nxt, pend_nxt});

    stall = '0;
    flush = '0;
    busy  = 1'b0;
    if (rst != RST_ENABLE) begin
      stall = emit ? (stall_base & ~low_mask) : stall_base;
      if (emit) begin
        flush         = low_mask;
        flush[STG_PC] = 1'b0;
      end
      busy = (state_q != RUN) || hold_vld || (flush_req && !emit_raw);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= RUN;
      pend_stg_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_stg_q <= pend_stg_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall != '0 && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      // flush_stage 0 emits no bits but is still a redirect worth counting.
      if (emit && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
